// File: rtl/io_port_bank.sv
// Memory-mapped bank of NUM_PORTS synchronised inputs / registered outputs with change-detect IRQ.
// Optional PORT_BANK_STROBE_EN adds a one-cycle out_strobe per port after each region-0 write.
module io_port_bank #(
  parameter int unsigned       NUM_PORTS     = 16,
  parameter int unsigned       DATA_W        = 8,
  parameter int unsigned       SYNC_STAGES   = 2,
  parameter logic [DATA_W-1:0] OUT_RESET_VAL = '0
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [5:0]                  addr,
  input  logic                        wr_en,
  input  logic                        rd_en,
  input  logic [DATA_W-1:0]           wdata,
  output logic [DATA_W-1:0]           rdata,
  output logic                        rvalid,
  input  logic [NUM_PORTS*DATA_W-1:0] port_in,
  output logic [NUM_PORTS*DATA_W-1:0] port_out,
  output logic                        irq
`ifdef PORT_BANK_STROBE_EN
  ,
  output logic [NUM_PORTS-1:0]        out_strobe
`endif
);

  localparam int unsigned        CW       = $clog2(SYNC_STAGES + 2);
  localparam logic [CW-1:0]      WARM_MAX = CW'(SYNC_STAGES + 1);

  logic [1:0] region;
  logic [3:0] idx;

  logic [NUM_PORTS-1:0][DATA_W-1:0] sync_q [SYNC_STAGES];
  logic [NUM_PORTS-1:0][DATA_W-1:0] sync_w;
  logic [NUM_PORTS-1:0][DATA_W-1:0] prev_q;
  logic [NUM_PORTS-1:0][DATA_W-1:0] pout_q, pout_d;
  logic [NUM_PORTS-1:0]             flag_q, flag_d;
  logic [NUM_PORTS-1:0]             mask_q, mask_d;
  logic [CW-1:0]                    cnt_q, cnt_d;
  logic                             warm_done;
  logic [DATA_W-1:0]                rd_val;
  logic [DATA_W-1:0]                rdata_q;
  logic                             rvalid_q;
  logic                             irq_q;
`ifdef PORT_BANK_STROBE_EN
  logic [NUM_PORTS-1:0]             strobe_q, strobe_d;
`endif

  assign region    = addr[5:4];
  assign idx       = addr[3:0];
  assign sync_w    = sync_q[SYNC_STAGES-1];
  assign warm_done = (cnt_q == WARM_MAX);
  assign cnt_d     = warm_done ? cnt_q : cnt_q + CW'(1);

  // Indices beyond NUM_PORTS match no loop iteration, so reads give 0 and writes drop.
  always_comb begin
    rd_val = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      if (32'(idx) == i) begin
        case (region)
          2'd0:    rd_val = sync_w[i];
          2'd1:    rd_val = pout_q[i];
          2'd2:    rd_val = DATA_W'(flag_q[i]);
          default: rd_val = DATA_W'(mask_q[i]);
        endcase
      end
    end
  end

  always_comb begin
    pout_d = pout_q;
    flag_d = flag_q;
    mask_d = mask_q;
`ifdef PORT_BANK_STROBE_EN
    strobe_d = '0;
`endif
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      if (wr_en && (32'(idx) == i)) begin
        case (region)
          2'd0: begin
            pout_d[i] = wdata;
`ifdef PORT_BANK_STROBE_EN
            strobe_d[i] = 1'b1;
`endif
          end
          2'd2:    if (wdata[0]) flag_d[i] = 1'b0;
          2'd3:    mask_d[i] = wdata[0];
          default: ;
        endcase
      end
      // Set is applied after the W1C so a coincident change keeps the flag.
      if (warm_done && (sync_w[i] != prev_q[i])) flag_d[i] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
      prev_q   <= '0;
      pout_q   <= {NUM_PORTS{OUT_RESET_VAL}};
      flag_q   <= '0;
      mask_q   <= '0;
      cnt_q    <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      irq_q    <= 1'b0;
`ifdef PORT_BANK_STROBE_EN
      strobe_q <= '0;
`endif
    end else begin
      sync_q[0] <= port_in;
      for (int unsigned s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      prev_q   <= sync_w;
      pout_q   <= pout_d;
      flag_q   <= flag_d;
      mask_q   <= mask_d;
      cnt_q    <= cnt_d;
      rvalid_q <= rd_en;
      if (rd_en) rdata_q <= rd_val;
      irq_q    <= |(flag_q & mask_q);
`ifdef PORT_BANK_STROBE_EN
      strobe_q <= strobe_d;
`endif
    end
  end

  assign port_out = pout_q;
  assign rdata    = rdata_q;
  assign rvalid   = rvalid_q;
  assign irq      = irq_q;
`ifdef PORT_BANK_STROBE_EN
  assign out_strobe = strobe_q;
`endif

endmodule

// File: tb/tb_io_port_bank.sv
// Self-checking bench for io_port_bank (NUM_PORTS=8, DATA_W=8, SYNC_STAGES=3, OUT_RESET_VAL=A5).
// A sample-history model predicts outputs every cycle; directed literals pin the model.
module tb_io_port_bank;
  localparam int N = 8;
  localparam int S = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  addr;
  logic        wr_en, rd_en;
  logic [7:0]  wdata;
  logic [7:0]  rdata;
  logic        rvalid;
  logic [63:0] port_in;
  logic [63:0] port_out;
  logic        irq;
`ifdef PORT_BANK_STROBE_EN
  logic [N-1:0] out_strobe;
`endif

  io_port_bank #(
    .NUM_PORTS(N), .DATA_W(8), .SYNC_STAGES(S), .OUT_RESET_VAL(8'hA5)
  ) dut (
    .clk(clk), .reset(reset), .addr(addr), .wr_en(wr_en), .rd_en(rd_en),
    .wdata(wdata), .rdata(rdata), .rvalid(rvalid), .port_in(port_in),
    .port_out(port_out), .irq(irq)
`ifdef PORT_BANK_STROBE_EN
    , .out_strobe(out_strobe)
`endif
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int tot_cnt  = 0;
  bit chk_en   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Model: port_in sampled at every edge k since reset is kept in samp[k].
  logic [7:0]  m_pout [N];
  bit          m_flag [N];
  bit          m_mask [N];
  logic [7:0]  m_rdata;
  bit          m_rvalid, m_irq;
  bit [N-1:0]  m_strobe;
  int          m_k;
  logic [63:0] samp [$];

  // Synchronised value of port p after j edges: the sample taken S-1 edges earlier.
  function automatic logic [7:0] synced(int j, int p);
    logic [63:0] v;
    if (j < S) return 8'h00;
    v = samp[j-S+1];
    return v[p*8 +: 8];
  endfunction

  function automatic logic [7:0] model_read(logic [5:0] a, int k);
    int p = int'(a[3:0]);
    if (p >= N) return 8'h00;
    case (a[5:4])
      2'd0:    return synced(k-1, p);
      2'd1:    return m_pout[p];
      2'd2:    return {7'b0, m_flag[p]};
      default: return {7'b0, m_mask[p]};
    endcase
  endfunction

  function automatic logic [63:0] pack_pout();
    logic [63:0] v;
    for (int p = 0; p < N; p++) v[p*8 +: 8] = m_pout[p];
    return v;
  endfunction

  always @(posedge clk or posedge reset) begin : model
    int  k;
    bit  nirq, hit, setf;
    if (reset) begin
      for (int p = 0; p < N; p++) begin
        m_pout[p] = 8'hA5; m_flag[p] = 0; m_mask[p] = 0;
      end
      m_rdata = 8'h00; m_rvalid = 0; m_irq = 0; m_strobe = '0; m_k = 0;
      samp.delete();
      samp.push_back('0);
    end else begin
      k = m_k + 1;
      samp.push_back(port_in);
      nirq = 0;
      for (int p = 0; p < N; p++) nirq |= m_flag[p] & m_mask[p];
      if (rd_en) m_rdata = model_read(addr, k);
      m_rvalid = rd_en;
      for (int p = 0; p < N; p++) begin
        setf = (k >= S + 2) && (synced(k-1, p) != synced(k-2, p));
        hit  = wr_en && (int'(addr[3:0]) == p);
        if (hit && addr[5:4] == 2'd2 && wdata[0]) m_flag[p] = 0;
        if (setf) m_flag[p] = 1;
        if (hit && addr[5:4] == 2'd3) m_mask[p] = wdata[0];
        if (hit && addr[5:4] == 2'd0) m_pout[p] = wdata;
        m_strobe[p] = hit && addr[5:4] == 2'd0;
      end
      m_irq = nirq;
      m_k = k;
    end
  end

  always @(negedge clk) begin
    if (!reset && chk_en) begin
      chk("port_out", port_out, pack_pout());
      chk("rvalid", {63'b0, rvalid}, {63'b0, m_rvalid});
      chk("rdata", {56'b0, rdata}, {56'b0, m_rdata});
      chk("irq", {63'b0, irq}, {63'b0, m_irq});
`ifdef PORT_BANK_STROBE_EN
      chk("out_strobe", {56'b0, out_strobe}, {56'b0, m_strobe});
`endif
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic wr(input logic [5:0] a, input logic [7:0] d);
    addr = a; wdata = d; wr_en = 1'b1;
    cyc();
    wr_en = 1'b0;
  endtask

  task automatic rd(input logic [5:0] a, output logic [7:0] v);
    addr = a; rd_en = 1'b1;
    cyc();
    rd_en = 1'b0;
    chk("rd_rvalid", {63'b0, rvalid}, 64'd1);
    v = rdata;
  endtask

  logic [7:0] v;

  initial begin
    reset = 1'b1; addr = '0; wr_en = 0; rd_en = 0; wdata = '0;
    port_in = {$urandom, $urandom};
    port_in[63:56] = 8'h11;
    #12;
    chk("reset_port_out", port_out, {8{8'hA5}});
    chk("reset_rvalid", {63'b0, rvalid}, 64'd0);
    chk("reset_irq", {63'b0, irq}, 64'd0);
    @(posedge clk); #2;
    reset = 1'b0;
    chk_en = 1;

    // Warm-up must not raise flags despite nonzero inputs at release.
    repeat (10) cyc();
    for (int p = 0; p < N; p++) begin
      rd(6'(6'h20 + p), v);
      chk("warm_flag", {56'b0, v}, 64'h0);
    end

    wr(6'h03, 8'h5C);
    chk("wr_port3", {56'b0, port_out[31:24]}, 64'h5C);
    chk("wr_port_out", port_out, 64'hA5A5A5A5_5CA5A5A5);
    rd(6'h13, v);
    chk("rd_back3", {56'b0, v}, 64'h5C);

    port_in[63:56] = 8'h3E;
    cyc(); cyc();
    rd(6'h07, v);
    chk("sync_early", {56'b0, v}, 64'h11);
    rd(6'h07, v);
    chk("sync_late", {56'b0, v}, 64'h3E);
    rd(6'h27, v);
    chk("flag7_set", {56'b0, v}, 64'h1);

    wr(6'h37, 8'h01);
    chk("irq_before", {63'b0, irq}, 64'd0);
    cyc();
    chk("irq_on", {63'b0, irq}, 64'd1);
    wr(6'h27, 8'h01);
    chk("irq_hold", {63'b0, irq}, 64'd1);
    cyc();
    chk("irq_off", {63'b0, irq}, 64'd0);

    // W1C lands on the same edge that detects a new change.
    port_in[63:56] = 8'h55;
    cyc(); cyc(); cyc();
    wr(6'h27, 8'h01);
    rd(6'h27, v);
    chk("flag_set_wins", {56'b0, v}, 64'h1);
    chk("irq_again", {63'b0, irq}, 64'd1);

    rd(6'h0C, v);
    chk("oor_rd0", {56'b0, v}, 64'h0);
    rd(6'h2C, v);
    chk("oor_rd2", {56'b0, v}, 64'h0);
    wr(6'h0C, 8'h77);
    chk("oor_wr", port_out, 64'hA5A5A5A5_5CA5A5A5);

    addr = 6'h02; wdata = 8'h11; wr_en = 1'b1;
    cyc();
`ifdef PORT_BANK_STROBE_EN
    chk("strobe_1", {63'b0, out_strobe[2]}, 64'd1);
`endif
    wdata = 8'h11;
    cyc();
    wr_en = 1'b0;
`ifdef PORT_BANK_STROBE_EN
    chk("strobe_2", {63'b0, out_strobe[2]}, 64'd1);
`endif
    cyc();
`ifdef PORT_BANK_STROBE_EN
    chk("strobe_3", {63'b0, out_strobe[2]}, 64'd0);
`endif
    chk("port2_val", {56'b0, port_out[23:16]}, 64'h11);

    for (int c = 0; c < 3000; c++) begin
      rd_en = 1'($urandom_range(0, 1));
      wr_en = ($urandom_range(0, 3) == 0);
      addr  = 6'($urandom_range(0, 63));
      wdata = 8'($urandom);
      if ($urandom_range(0, 7) == 0) port_in[$urandom_range(0, N-1)*8 +: 8] = 8'($urandom);
      cyc();
    end
    rd_en = 0; wr_en = 0;
    cyc();

    // Mid-cycle reset with a read and a write in flight.
    rd_en = 1'b1; wr_en = 1'b1; addr = 6'h01; wdata = 8'h42;
    #2;
    reset = 1'b1;
    rd_en = 1'b0; wr_en = 1'b0;
    #1;
    chk("mid_rst_port_out", port_out, {8{8'hA5}});
    chk("mid_rst_rvalid", {63'b0, rvalid}, 64'd0);
    chk("mid_rst_irq", {63'b0, irq}, 64'd0);
    @(posedge clk); #1;
    chk("rst_hold_rvalid", {63'b0, rvalid}, 64'd0);
    chk("rst_hold_port_out", port_out, {8{8'hA5}});
    #1;
    reset = 1'b0;
    repeat (8) cyc();
    rd(6'h11, v);
    chk("post_rst_port1", {56'b0, v}, 64'hA5);
    for (int p = 0; p < N; p++) begin
      rd(6'(6'h20 + p), v);
      chk("post_rst_flag", {56'b0, v}, 64'h0);
    end
    cyc();

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end
endmodule

// File: doc/io_port_bank.md
Name: io_port_bank

Overview:
- Parametrised, memory-mapped I/O port bank for the computer; replaces hard-wired 16×8-bit port_in/port_out arrays.
- Provides NUM_PORTS ports of DATA_W bits, with input synchronisers, registered outputs, and output readback.
- Per-port change-detect flags with maskable interrupt; single-master CPU-side register bus with 1-cycle read latency.

Parameters:
- NUM_PORTS, 16, number of input/output port pairs; legal range 1..16.
- DATA_W, 8, width of each port and of the bus data; legal range 1..32.
- SYNC_STAGES, 2, flip-flop stages on each port_in bit; legal range 2..4.
- OUT_RESET_VAL, 0, value loaded into every port_out register on reset; DATA_W bits.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- addr  in  6  register address; region = addr[5:4], index = addr[3:0].
- wr_en  in  1  write strobe, one cycle per write.
- rd_en  in  1  read strobe, one cycle per read.
- wdata  in  DATA_W  write data.
- rdata  out  DATA_W  read data, valid when rvalid = 1.
- rvalid  out  1  read-data valid pulse.
- port_in  in  NUM_PORTS*DATA_W  flattened external inputs; port i = bits [i*DATA_W +: DATA_W]; asynchronous to clk.
- port_out  out  NUM_PORTS*DATA_W  flattened registered outputs; same packing as port_in.
- irq  out  1  registered interrupt request.

Behaviour:
- Reset (async assert, sync deassert use):
  - port_out = OUT_RESET_VAL on all ports.
  - Flags, masks, sync chains, prev-sample registers, rdata, rvalid, irq = 0.
  - Warm-up counter = 0.
- Address map, region by addr[5:4]:
  - 0: read returns synchronised port_in[idx]; write loads port_out[idx] from wdata.
  - 1: read returns port_out[idx]; write ignored.
  - 2: read returns {0..., flag[idx]}; write with wdata[0]=1 clears flag[idx] (W1C); wdata[0]=0 has no effect.
  - 3: read/write mask[idx] in bit 0; upper bits read 0, ignored on write.
- idx >= NUM_PORTS: reads return 0 with rvalid; writes ignored.
- Read timing: rd_en in cycle N gives rdata and rvalid = 1 in cycle N+1; rvalid = 0 otherwise. rdata holds its last value when rvalid = 0.
- Write timing: write takes effect at the clock edge where wr_en = 1; port_out changes that edge.
- wr_en and rd_en both high, same address: read returns the pre-write value.
- Synchroniser: port_in reaches the sync output after SYNC_STAGES edges. prev = sync output delayed one cycle.
- Warm-up: counter runs from reset release and saturates at SYNC_STAGES+1. Change detect is disabled until saturation, so no spurious flags from reset values.
- Change detect: after warm-up, sync != prev for port i sets flag[i] next edge.
  - Set and W1C clear in the same cycle: set wins, flag stays 1.
- irq: registered OR over i of (flag[i] & mask[i]); one-cycle delay from the flag/mask update.
- Reset asserted mid-transaction: a pending rvalid is dropped; no partial writes.

Optional Feature:
- Macro PORT_BANK_STROBE_EN.
- When defined:
  - Adds output out_strobe [NUM_PORTS-1:0], reset 0.
  - out_strobe[i] pulses high for exactly one cycle, the cycle after a region-0 write to port i, including writes of an unchanged value.
  - Back-to-back writes give back-to-back pulses.
- When undefined: port absent, no strobe logic.

Test Plan:
- Reset: assert reset mid-cycle with OUT_RESET_VAL=8'hA5 -> all port_out = A5 immediately; rvalid, irq, flags = 0.
- Write port 3 = 8'h5C, then read addr 6'h13 -> port_out[3] = 5C the edge after the write; read gives rdata = 5C with rvalid one cycle after rd_en.
- Drive port_in[7] = 8'h3E after warm-up:
  - Read addr 6'h07 -> 3E visible SYNC_STAGES cycles after the change.
  - flag[7] set: read addr 6'h27 returns 1.
  - No flags set during warm-up when port_in is nonzero at reset release.
- Write mask[7] = 1 (addr 6'h37) with flag[7] set -> irq = 1 next cycle. W1C at 6'h27 -> irq = 0 one cycle after the flag clears. Clear coincident with a new change on port 7 -> flag stays 1.
- Access idx 12 with NUM_PORTS=8 -> read returns 0 with rvalid; write leaves all port_out unchanged.
- PORT_BANK_STROBE_EN defined: writes to port 2 on cycles 10 and 11 -> out_strobe[2] high on cycles 11 and 12 only.
